// File: rtl/pq_req_arb_if.sv
// pq_req_arb_if
//   Bundles the requester-side handshake and the priority-queue command bus
//   used by pq_req_arb.
//   master : the arbiter view (drives acks, response word and PQ commands)
//   slave  : the environment view (requesters plus the PQ instance)
// Signals:
//   req_enq/req_deq  per-requester request bits, both set = replace
//   req_kv           per-requester enqueue word, slice i = [(i+1)*KVW-1 : i*KVW]
//   req_ack          one-cycle one-hot ack
//   rsp_kv/rsp_err   dequeued word and error flag, valid with req_ack
//   pq_enq/pq_deq    PQ command strobes, pq_kvi command word
//   pq_kvo           PQ head word, pq_busy accept window, pq_empty/pq_full status
interface pq_req_arb_if #(
    parameter int NREQ = 4,
    parameter int KVW  = 16
);
    logic [NREQ-1:0]     req_enq;
    logic [NREQ-1:0]     req_deq;
    logic [NREQ*KVW-1:0] req_kv;
    logic [NREQ-1:0]     req_ack;
    logic [KVW-1:0]      rsp_kv;
    logic                rsp_err;
    logic                pq_enq;
    logic                pq_deq;
    logic [KVW-1:0]      pq_kvi;
    logic [KVW-1:0]      pq_kvo;
    logic                pq_busy;
    logic                pq_empty;
    logic                pq_full;

    modport master (
        input  req_enq, req_deq, req_kv, pq_kvo, pq_busy, pq_empty, pq_full,
        output req_ack, rsp_kv, rsp_err, pq_enq, pq_deq, pq_kvi
    );

    modport slave (
        output req_enq, req_deq, req_kv, pq_kvo, pq_busy, pq_empty, pq_full,
        input  req_ack, rsp_kv, rsp_err, pq_enq, pq_deq, pq_kvi
    );
endinterface

// File: rtl/pq_req_arb.sv
// pq_req_arb
//   Round-robin sequencer sharing one priority queue among NREQ requesters.
//   A winning enqueue, dequeue or replace request is issued as exactly one
//   single-cycle PQ command inside the PQ accept window (pq_busy==1); the
//   dequeued head word is captured and the requester gets a one-cycle ack.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  pq_req_arb_if.master (requester handshake + PQ command bus)
// Build option:
//   PQ_ARB_REJECT_EN  when defined, a request that is illegal for the current
//                     PQ state (enq-only on full, deq/replace on empty) is
//                     acked immediately with rsp_err=1 instead of stalling.
//
// state | meaning
// ARB   | pick first eligible requester from rr_ptr, latch its command
// ISSUE | wait for pq_busy, present command, capture head on dequeue
// ACK   | pulse req_ack[sel], advance rr_ptr past the winner
module pq_req_arb #(
    parameter int NREQ      = 4,
    parameter int KEY_WIDTH = 8,
    parameter int VAL_WIDTH = 8,
    parameter int KVW       = KEY_WIDTH + VAL_WIDTH
) (
    input logic          clk,
    input logic          rst,
    pq_req_arb_if.master bus
);
    localparam int SELW = $clog2(NREQ);

    typedef enum logic [1:0] {ARB, ISSUE, ACK} state_t;

    state_t          r_state;
    logic [SELW-1:0] r_rr_ptr;
    logic [SELW-1:0] r_sel;
    logic            r_op_enq;
    logic            r_op_deq;
    logic [KVW-1:0]  r_kvi;
    logic [KVW-1:0]  r_rsp_kv;
    logic [NREQ-1:0] r_ack;

    logic [NREQ-1:0] w_legal;
    logic [NREQ-1:0] w_elig;
    logic            w_found;
    logic [SELW-1:0] w_win;

    // Replace is legal on a full queue: the dequeue frees the slot it fills.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_legal[i] = (bus.req_enq[i] & ~bus.req_deq[i] & ~bus.pq_full)
                       | (bus.req_deq[i] & ~bus.pq_empty);
        end
    end

`ifdef PQ_ARB_REJECT_EN
    logic            r_err;
    logic [NREQ-1:0] w_bad;
    logic            w_win_bad;

    assign w_bad     = (bus.req_enq | bus.req_deq) & ~w_legal;
    assign w_elig    = bus.req_enq | bus.req_deq;
    assign w_win_bad = w_bad[w_win];
    assign bus.rsp_err = r_err;
`else
    assign w_elig      = w_legal;
    assign bus.rsp_err = 1'b0;
`endif

    // Rotating first-eligible search starting at rr_ptr.
    always_comb begin
        logic [SELW:0] v_sum;
        v_sum   = '0;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            v_sum = {1'b0, r_rr_ptr} + (SELW+1)'(k);
            if (v_sum >= (SELW+1)'(NREQ)) begin
                v_sum = v_sum - (SELW+1)'(NREQ);
            end
            if (!w_found && w_elig[v_sum[SELW-1:0]]) begin
                w_found = 1'b1;
                w_win   = v_sum[SELW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ARB;
            r_rr_ptr <= '0;
            r_sel    <= '0;
            r_op_enq <= 1'b0;
            r_op_deq <= 1'b0;
            r_kvi    <= '0;
            r_rsp_kv <= '0;
            r_ack    <= '0;
`ifdef PQ_ARB_REJECT_EN
            r_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ARB: begin
                    if (w_found) begin
                        r_sel    <= w_win;
                        r_op_enq <= bus.req_enq[w_win];
                        r_op_deq <= bus.req_deq[w_win];
                        r_kvi    <= bus.req_kv[int'(w_win)*KVW +: KVW];
`ifdef PQ_ARB_REJECT_EN
                        if (w_win_bad) begin
                            r_ack   <= NREQ'(1) << w_win;
                            r_err   <= 1'b1;
                            r_state <= ACK;
                        end else
`endif
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.pq_busy) begin
                        if (r_op_deq) begin
                            r_rsp_kv <= bus.pq_kvo;
                        end
                        r_ack   <= NREQ'(1) << r_sel;
                        r_state <= ACK;
                    end
                end
                ACK: begin
                    r_ack    <= '0;
`ifdef PQ_ARB_REJECT_EN
                    r_err    <= 1'b0;
`endif
                    r_rr_ptr <= (r_sel == SELW'(NREQ-1)) ? '0 : r_sel + 1'b1;
                    r_state  <= ARB;
                end
                default: r_state <= ARB;
            endcase
        end
    end

    // Commands are combinational on pq_busy so they land inside the window;
    // rst gates them so a reset cycle never reaches the PQ.
    assign bus.pq_enq  = (r_state == ISSUE) & r_op_enq & bus.pq_busy & ~rst;
    assign bus.pq_deq  = (r_state == ISSUE) & r_op_deq & bus.pq_busy & ~rst;
    assign bus.pq_kvi  = r_kvi;
    assign bus.rsp_kv  = r_rsp_kv;
    assign bus.req_ack = r_ack;
endmodule

// File: tb/tb_pq_req_arb.sv
module tb_pq_req_arb;
    localparam int NREQ = 4;
    localparam int KVW  = 16;
    localparam int CAP  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pq_req_arb_if #(.NREQ(NREQ), .KVW(KVW)) bus();

    pq_req_arb #(.NREQ(NREQ), .KEY_WIDTH(8), .VAL_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             idx;
        logic           do_enq;
        logic           do_deq;
        logic [KVW-1:0] kvi;
        logic           chk_kv;
        logic [KVW-1:0] rsp;
        logic           err;
    } exp_t;

    typedef struct {
        int             idx;
        logic           e;
        logic           d;
        logic [KVW-1:0] kv;
        logic           chk_kv;
        logic [KVW-1:0] rsp;
    } vec_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   cmd_cnt = 0;
    int   req_cyc[NREQ];
    int   busy_mode = 0;
    logic force_full = 1'b0;
    logic mdl_full = 1'b0;
    logic [KVW-1:0] pq_q[$];

    assign bus.pq_full = mdl_full | force_full;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference priority queue: sorted ascending, head = minimum key.
    initial begin
        logic           e, d;
        logic [KVW-1:0] w;
        int             pos;
        bus.pq_kvo   = '0;
        bus.pq_empty = 1'b1;
        forever begin
            @(posedge clk);
            e = bus.pq_enq;
            d = bus.pq_deq;
            w = bus.pq_kvi;
            #1;
            if (d && pq_q.size() > 0) void'(pq_q.pop_front());
            if (e) begin
                pos = 0;
                while (pos < pq_q.size() && pq_q[pos] < w) pos++;
                pq_q.insert(pos, w);
            end
            bus.pq_kvo   = (pq_q.size() > 0) ? pq_q[0] : '0;
            bus.pq_empty = (pq_q.size() == 0);
            mdl_full     = (pq_q.size() >= CAP);
        end
    end

    initial begin
        bus.pq_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (busy_mode)
                0:       bus.pq_busy = ($urandom_range(0, 2) != 0);
                1:       bus.pq_busy = 1'b1;
                default: bus.pq_busy = 1'b0;
            endcase
        end
    end

    // Monitor: every command and every ack is matched against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.pq_enq || bus.pq_deq) begin
                chk("cmd_in_busy_window", bus.pq_busy, 1);
                if (sb.size() == 0) begin
                    chk("cmd_without_request", {bus.pq_enq, bus.pq_deq}, 2'b00);
                end else begin
                    chk("cmd_enq", bus.pq_enq, sb[0].do_enq);
                    chk("cmd_deq", bus.pq_deq, sb[0].do_deq);
                    if (sb[0].do_enq) chk("pq_kvi", bus.pq_kvi, sb[0].kvi);
                end
                cmd_cnt++;
            end
            if (bus.req_ack != '0) begin
                if (sb.size() == 0) begin
                    chk("ack_without_request", bus.req_ack, 0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_idx", bus.req_ack, 64'(1) << e.idx);
                    chk("rsp_err", bus.rsp_err, e.err);
                    if (e.chk_kv) chk("rsp_kv", bus.rsp_kv, e.rsp);
                    chk("cmds_per_ack", cmd_cnt, e.err ? 0 : 1);
                    chk("latency_ge3", ((cyc - req_cyc[e.idx] + 1) >= 3), 1);
                end
                cmd_cnt = 0;
            end
        end
    end

    task automatic raise(input int i, input logic e, input logic d, input logic [KVW-1:0] kv);
        bus.req_enq[i] = e;
        bus.req_deq[i] = d;
        bus.req_kv[i*KVW +: KVW] = kv;
        req_cyc[i] = cyc;
    endtask

    task automatic expect_ack(input int i, input logic e, input logic d, input logic [KVW-1:0] kv,
                              input logic chk_kv, input logic [KVW-1:0] rsp, input logic err);
        sb.push_back('{i, e, d, kv, chk_kv, rsp, err});
    endtask

    // Requester behaviour: drop a request right after its ack.
    task automatic serve(input int budget, input bit stop_idle);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            bus.req_enq &= ~bus.req_ack;
            bus.req_deq &= ~bus.req_ack;
            if (stop_idle && (bus.req_enq | bus.req_deq) == '0) return;
        end
        if (stop_idle) begin
            chk("ack_timeout_pending", bus.req_enq | bus.req_deq, 0);
            bus.req_enq = '0;
            bus.req_deq = '0;
            sb.delete();
        end
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{0, 1'b1, 1'b0, 16'h080E, 1'b0, 16'h0000};
        tbl[1] = '{1, 1'b1, 1'b0, 16'h0B0B, 1'b0, 16'h0000};
        tbl[2] = '{2, 1'b1, 1'b0, 16'h0909, 1'b0, 16'h0000};
        tbl[3] = '{3, 1'b1, 1'b0, 16'h0C0C, 1'b0, 16'h0000};
        tbl[4] = '{2, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h080E};
        tbl[5] = '{1, 1'b1, 1'b1, 16'h0D0D, 1'b1, 16'h0909};
        tbl[6] = '{0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0B0B};

        bus.req_enq = '0;
        bus.req_deq = '0;
        bus.req_kv  = '0;
        for (int i = 0; i < NREQ; i++) req_cyc[i] = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ack", bus.req_ack, 0);
        chk("reset_rsp_kv", bus.rsp_kv, 0);
        chk("reset_rsp_err", bus.rsp_err, 0);
        chk("reset_pq_kvi", bus.pq_kvi, 0);
        chk("reset_pq_cmd", {bus.pq_enq, bus.pq_deq}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single-requester enqueue / dequeue / replace sequence.
        for (int t = 0; t < 7; t++) begin
            @(posedge clk);
            #1;
            expect_ack(tbl[t].idx, tbl[t].e, tbl[t].d, tbl[t].kv, tbl[t].chk_kv, tbl[t].rsp, 1'b0);
            raise(tbl[t].idx, tbl[t].e, tbl[t].d, tbl[t].kv);
            serve(200, 1'b1);
        end

        // Queue now holds {12,12},{13,13}. Full blocks enq-only but not deq.
        @(posedge clk);
        #1;
        force_full = 1'b1;
        expect_ack(1, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0C0C, 1'b0);
`ifdef PQ_ARB_REJECT_EN
        expect_ack(0, 1'b1, 1'b0, 16'h0505, 1'b1, 16'h0C0C, 1'b1);
        raise(0, 1'b1, 1'b0, 16'h0505);
        raise(1, 1'b0, 1'b1, 16'h0000);
        serve(200, 1'b1);
        force_full = 1'b0;
`else
        raise(0, 1'b1, 1'b0, 16'h0505);
        raise(1, 1'b0, 1'b1, 16'h0000);
        serve(40, 1'b0);
        chk("enq_held_while_full", bus.req_enq[0], 1);
        chk("deq_served_while_full", bus.req_deq[1], 0);
        @(posedge clk);
        #1;
        expect_ack(0, 1'b1, 1'b0, 16'h0505, 1'b0, 16'h0000, 1'b0);
        force_full = 1'b0;
        serve(200, 1'b1);
`endif

        // Reset while an enqueue waits in ISSUE and the window opens.
        busy_mode = 2;
        @(posedge clk);
        #1;
        raise(2, 1'b1, 1'b0, 16'h0707);
        repeat (4) @(posedge clk);
        busy_mode = 1;
        #1;
        rst = 1'b1;
        bus.req_enq[2] = 1'b0;
        @(negedge clk);
        chk("rst_cycle_no_enq", bus.pq_enq, 0);
        chk("rst_cycle_no_deq", bus.pq_deq, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        busy_mode = 0;
        @(negedge clk);
        chk("post_rst_ack", bus.req_ack, 0);
        chk("post_rst_rsp_kv", bus.rsp_kv, 0);
        chk("post_rst_pq_kvi", bus.pq_kvi, 0);
        repeat (3) @(negedge clk);

        // All four requesters at once: rr_ptr restarts at 0.
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            expect_ack(i, 1'b1, 1'b0, 16'h2100 + 16'(i), 1'b0, 16'h0000, 1'b0);
            raise(i, 1'b1, 1'b0, 16'h2100 + 16'(i));
        end
        serve(300, 1'b1);

        // Pointer wrapped past 3, so 0 beats 3.
        @(posedge clk);
        #1;
        expect_ack(0, 1'b1, 1'b0, 16'h3000, 1'b0, 16'h0000, 1'b0);
        expect_ack(3, 1'b1, 1'b0, 16'h3303, 1'b0, 16'h0000, 1'b0);
        raise(0, 1'b1, 1'b0, 16'h3000);
        raise(3, 1'b1, 1'b0, 16'h3303);
        serve(200, 1'b1);

        // Head check after everything above.
        @(posedge clk);
        #1;
`ifdef PQ_ARB_REJECT_EN
        expect_ack(2, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0D0D, 1'b0);
`else
        expect_ack(2, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0505, 1'b0);
`endif
        raise(2, 1'b0, 1'b1, 16'h0000);
        serve(200, 1'b1);

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
